// File: rtl/addsub_bcd_scan.sv
// Sequential add/sub with serial double-dabble BCD conversion and a multiplexed seven-segment scan.
// Optional macro SIGNED_DISPLAY_EN: shows negative differences as sign + magnitude and adds the neg port.
module addsub_bcd_scan #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WIDTH-1:0]  x,
  input  logic [WIDTH-1:0]  y,
  input  logic              sub,
  output logic              busy,
  output logic              done,
  output logic              carry,
  output logic [WIDTH:0]    result,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
`ifdef SIGNED_DISPLAY_EN
  ,
  output logic              neg
`endif
);

  localparam int unsigned CW = $clog2(WIDTH + 2);
  localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned BW = 4 * DIGITS;

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_CONV, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_x, r_y;
  logic             r_sub;
  logic [WIDTH:0]   r_shift;
  logic [BW-1:0]    r_bcd;
  logic [CW-1:0]    r_cnt;
  logic [BW-1:0]    r_disp;
  logic [DW-1:0]    r_div;
  logic [IW-1:0]    r_idx;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_load;
  logic [BW-1:0]    w_adj;
  logic [BW-1:0]    w_bcd_next;
  logic             w_last;
  logic [BW-1:0]    w_disp_next;
  logic             w_wrap;
  logic [IW-1:0]    w_idx_next;
  logic [3:0]       w_digit;
  logic [6:0]       w_seg_next;
  logic [DIGITS-1:0] w_an_next;

`ifdef SIGNED_DISPLAY_EN
  logic [WIDTH-1:0] w_mag;
  logic             r_neg_pend;
  logic             r_neg;
  logic             w_neg_next;
  assign neg = r_neg;
`endif

  function automatic logic [6:0] f_enc(input logic [3:0] d);
    case (d)
      4'd0:    f_enc = 7'h7E;
      4'd1:    f_enc = 7'h30;
      4'd2:    f_enc = 7'h6D;
      4'd3:    f_enc = 7'h79;
      4'd4:    f_enc = 7'h33;
      4'd5:    f_enc = 7'h5B;
      4'd6:    f_enc = 7'h5F;
      4'd7:    f_enc = 7'h70;
      4'd8:    f_enc = 7'h7F;
      4'd9:    f_enc = 7'h7B;
      default: f_enc = 7'h00;
    endcase
  endfunction

  always_comb begin
    w_sum = {1'b0, r_x} + {1'b0, (r_sub ? ~r_y : r_y)} + {{WIDTH{1'b0}}, r_sub};
`ifdef SIGNED_DISPLAY_EN
    w_mag  = r_y - r_x;
    w_load = (r_sub && !w_sum[WIDTH]) ? {1'b0, w_mag} : w_sum;
`else
    w_load = w_sum;
`endif
  end

  // Double-dabble step: correct nibbles >= 5, then shift in the next binary bit.
  always_comb begin
    w_adj = r_bcd;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5)
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
    w_bcd_next = (w_adj << 1) | BW'(r_shift[WIDTH]);
  end

  assign w_last = (r_state == S_CONV) && (r_cnt == CW'(WIDTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      carry   <= 1'b0;
      result  <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_sub   <= 1'b0;
      r_shift <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_disp  <= '0;
`ifdef SIGNED_DISPLAY_EN
      r_neg_pend <= 1'b0;
      r_neg      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x     <= x;
            r_y     <= y;
            r_sub   <= sub;
            busy    <= 1'b1;
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          result  <= w_sum;
          carry   <= w_sum[WIDTH];
          r_shift <= w_load;
          r_bcd   <= '0;
          r_cnt   <= '0;
`ifdef SIGNED_DISPLAY_EN
          r_neg_pend <= r_sub && !w_sum[WIDTH];
`endif
          r_state <= S_CONV;
        end
        S_CONV: begin
          r_bcd   <= w_bcd_next;
          r_shift <= r_shift << 1;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            done    <= 1'b1;
            r_disp  <= w_bcd_next;
`ifdef SIGNED_DISPLAY_EN
            r_neg   <= r_neg_pend;
`endif
            r_state <= S_DONE;
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // seg/an are built from the post-edge index and display so they never lag a display update.
  always_comb begin
    w_disp_next = w_last ? w_bcd_next : r_disp;
    w_wrap      = (r_div == DW'(SCAN_DIV - 1));
    w_idx_next  = r_idx;
    if (w_wrap)
      w_idx_next = (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
    w_digit    = w_disp_next[4*w_idx_next +: 4];
    w_seg_next = f_enc(w_digit);
`ifdef SIGNED_DISPLAY_EN
    w_neg_next = w_last ? r_neg_pend : r_neg;
    if (w_neg_next && (w_idx_next == IW'(DIGITS - 1)))
      w_seg_next = 7'h01;
`endif
    w_an_next = DIGITS'(1) << w_idx_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
      r_idx <= '0;
      an    <= DIGITS'(1);
      seg   <= 7'h7E;
    end else begin
      r_div <= w_wrap ? '0 : r_div + DW'(1);
      r_idx <= w_idx_next;
      an    <= w_an_next;
      seg   <= w_seg_next;
    end
  end

endmodule

// File: tb/tb_addsub_bcd_scan.sv
// Scoreboard bench for addsub_bcd_scan (WIDTH=8, DIGITS=4, SCAN_DIV=4), directed vectors.
module tb_addsub_bcd_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] x = '0, y = '0;
  logic       sub = 1'b0;
  logic       busy, done, carry;
  logic [8:0] result;
  logic [6:0] seg;
  logic [3:0] an;
`ifdef SIGNED_DISPLAY_EN
  logic       neg;
`endif

  addsub_bcd_scan #(.WIDTH(8), .DIGITS(4), .SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y), .sub(sub),
    .busy(busy), .done(done), .carry(carry), .result(result), .seg(seg), .an(an)
`ifdef SIGNED_DISPLAY_EN
    , .neg(neg)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0]  res;
    logic        c;
    logic        n;
    logic [15:0] digs;
    logic [31:0] st;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_done = 0;
  int   n_mon = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, want);
    end
  endtask

  // Nibble 'hA stands for the minus sign.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'h0: seg_of = 7'h7E;  4'h1: seg_of = 7'h30;
      4'h2: seg_of = 7'h6D;  4'h3: seg_of = 7'h79;
      4'h4: seg_of = 7'h33;  4'h5: seg_of = 7'h5B;
      4'h6: seg_of = 7'h5F;  4'h7: seg_of = 7'h70;
      4'h8: seg_of = 7'h7F;  4'h9: seg_of = 7'h7B;
      4'hA: seg_of = 7'h01;
      default: seg_of = 7'h00;
    endcase
  endfunction

  // Monitor: pops one expectation per done pulse, then scans all digits.
  initial begin
    exp_t e;
    logic [6:0] got [4];
    int idx;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        n_done++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done at cycle %0d", cyc);
        end else begin
          e = q.pop_front();
          chk("result", 32'(result), 32'(e.res));
          chk("carry", 32'(carry), 32'(e.c));
          chk("latency", 32'(cyc + 1 - int'(e.st)), 32'd11);
          chk("busy_in_done", 32'(busy), 32'd1);
`ifdef SIGNED_DISPLAY_EN
          chk("neg", 32'(neg), 32'(e.n));
`endif
          for (int i = 0; i < 4; i++) got[i] = 7'h55;
          for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            if (!$onehot(an)) begin
              checks++; errors++;
              $display("FAIL an_onehot got %b expected one-hot", an);
            end else begin
              idx = 0;
              for (int i = 0; i < 4; i++) if (an[i]) idx = i;
              got[idx] = seg;
            end
          end
          for (int i = 0; i < 4; i++)
            chk($sformatf("digit%0d_seg", i), 32'(got[i]), 32'(seg_of(e.digs[4*i +: 4])));
        end
        n_mon++;
      end
    end
  end

  task automatic issue(input int ix, input int iy, input int isub, input int ires,
                       input int ic, input int idigs, input int ineg, input bit push);
    exp_t e;
    @(negedge clk);
    x = 8'(ix); y = 8'(iy); sub = isub[0]; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    x = 8'($urandom); y = 8'($urandom); sub = 1'($urandom);
    chk("busy_after_start", 32'(busy), 32'd1);
    e.res = 9'(ires); e.c = ic[0]; e.n = ineg[0]; e.digs = 16'(idigs); e.st = 32'(cyc);
    if (push) q.push_back(e);
  endtask

  task automatic wait_mon(input string nm);
    int base;
    bit ok;
    base = n_mon;
    ok = 0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (n_mon > base) ok = 1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout got no done expected done within 200 cycles", nm);
    end
  endtask

  localparam int NV = 7;
  int vx   [NV] = '{200, 255, 50, 20, 0, 0, 0};
  int vy   [NV] = '{100, 255, 20, 50, 0, 0, 255};
  int vsub [NV] = '{0, 0, 1, 1, 0, 1, 1};
  int vres [NV] = '{'h12C, 'h1FE, 'h11E, 'h0E2, 'h000, 'h100, 'h001};
  int vc   [NV] = '{1, 1, 1, 0, 0, 1, 0};
`ifdef SIGNED_DISPLAY_EN
  int vdig [NV] = '{'h0300, 'h0510, 'h0286, 'hA030, 'h0000, 'h0256, 'hA255};
  int vneg [NV] = '{0, 0, 0, 1, 0, 0, 1};
`else
  int vdig [NV] = '{'h0300, 'h0510, 'h0286, 'h0226, 'h0000, 'h0256, 'h0001};
  int vneg [NV] = '{0, 0, 0, 0, 0, 0, 0};
`endif

  initial begin
    int d0;
    logic [6:0] sg [4];
    #22;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_carry", 32'(carry), 32'd0);
    chk("rst_an", 32'(an), 32'h1);
    chk("rst_seg", 32'(seg), 32'h7E);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("scan_an_%0d", n), 32'(an), 32'(4'b0001 << ((n / 4) % 4)));
      chk($sformatf("scan_seg_%0d", n), 32'(seg), 32'h7E);
    end
    chk("idle_busy", 32'(busy), 32'd0);

    for (int v = 0; v < NV; v++) begin
      issue(vx[v], vy[v], vsub[v], vres[v], vc[v], vdig[v], vneg[v], 1'b1);
      wait_mon($sformatf("vec%0d", v));
    end

    // Second start during conversion must be ignored.
    d0 = n_done;
    issue(200, 100, 0, 'h12C, 1, 'h0300, 0, 1'b1);
    repeat (2) @(negedge clk);
    x = 8'd1; y = 8'd1; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_mon("ignored_start");
    repeat (30) @(negedge clk);
    chk("single_done", 32'(n_done - d0), 32'd1);

    // Reset mid-operation: no done, display cleared.
    issue(255, 255, 0, 0, 0, 0, 0, 1'b0);
    d0 = n_done;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_an", 32'(an), 32'h1);
    chk("midrst_seg", 32'(seg), 32'h7E);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) sg[i] = 7'h55;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (an == (4'b0001 << i)) sg[i] = seg;
    end
    chk("midrst_no_done", 32'(n_done - d0), 32'd0);
    for (int i = 0; i < 4; i++) chk($sformatf("midrst_digit%0d", i), 32'(sg[i]), 32'h7E);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
